// File: rtl/uart_frame_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_frame_ctrl
//   Frame sequencer between the byte UART, the image RAM and the CNN core.
//   Hunts for SYNC_BYTE, streams IMG_BYTES pixel bytes into image RAM, starts
//   the CNN, waits for its class index and sends it back as one UART byte.
//
//   Optional feature macro: UART_FRAME_CHECKSUM_EN
//     When defined, one extra byte after the pixels must equal the 8-bit
//     wrap-around sum of the pixels; a mismatch flags err and replies 8'hEE
//     without starting the CNN.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   uart_rx_rdy/data   received byte (level valid, held until consumed)
//   uart_clr_rx_rdy    consume strobe, combinational copy of uart_rx_rdy
//   uart_trmt          one-cycle transmit request
//   uart_tx_data       reply byte, stable from trmt until tx_done
//   uart_tx_done       transmitter idle (cleared by the UART on trmt)
//   uart_rst           one-cycle UART reset after an RX timeout abort
//   mem_we/waddr/wdata image RAM write port (registered)
//   cnn_start          one-cycle CNN start
//   cnn_done/result    CNN finished / class index
//   busy               high outside IDLE
//   err                sticky error, cleared by the next sync byte
// -----------------------------------------------------------------------------
module uart_frame_ctrl #(
  parameter int unsigned IMG_BYTES  = 784,
  parameter int unsigned ADDR_W     = 10,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int unsigned RX_TIMEOUT = 2500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx_rdy,
  input  logic [7:0]        uart_rx_data,
  output logic              uart_clr_rx_rdy,
  output logic              uart_trmt,
  output logic [7:0]        uart_tx_data,
  input  logic              uart_tx_done,
  output logic              uart_rst,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic              cnn_start,
  input  logic              cnn_done,
  input  logic [3:0]        cnn_result,
  output logic              busy,
  output logic              err
);

  localparam int unsigned       TO_W      = $clog2(RX_TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(RX_TIMEOUT - 1);

`ifdef UART_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHK, S_START, S_WAIT_CNN, S_SEND, S_WAIT_TX
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT_CNN, S_SEND, S_WAIT_TX
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;
  logic [7:0]          tx_q, tx_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                urst_q, urst_d;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
`endif

  // Silence in LOAD/CHK has lasted RX_TIMEOUT cycles; a byte arriving in the
  // same cycle wins over the abort.
  logic rx_expired;
  assign rx_expired = !uart_rx_rdy && (tcnt_q == TO_LAST);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tcnt_d  = tcnt_q;
    tx_d    = tx_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    urst_d  = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (uart_rx_rdy && uart_rx_data == SYNC_BYTE) begin
          state_d = S_LOAD;
          err_d   = 1'b0;
          count_d = '0;
          tcnt_d  = '0;
`ifdef UART_FRAME_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_LOAD: begin
        if (uart_rx_rdy) begin
          we_d    = 1'b1;
          waddr_d = count_q;
          wdata_d = uart_rx_data;
          tcnt_d  = '0;
`ifdef UART_FRAME_CHECKSUM_EN
          sum_d   = sum_q + uart_rx_data;
`endif
          // count stops on the last address instead of wrapping
          if (count_q == LAST_ADDR) begin
`ifdef UART_FRAME_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_START;
`endif
          end else begin
            count_d = count_q + 1'b1;
          end
        end else if (rx_expired) begin
          err_d   = 1'b1;
          urst_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tcnt_q != '1) begin
          tcnt_d  = tcnt_q + 1'b1;
        end
      end
`ifdef UART_FRAME_CHECKSUM_EN
      S_CHK: begin
        if (uart_rx_rdy) begin
          tcnt_d = '0;
          if (uart_rx_data == sum_q) begin
            state_d = S_START;
          end else begin
            err_d   = 1'b1;
            tx_d    = 8'hEE;
            state_d = S_SEND;
          end
        end else if (rx_expired) begin
          err_d   = 1'b1;
          urst_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tcnt_q != '1) begin
          tcnt_d  = tcnt_q + 1'b1;
        end
      end
`endif
      S_START:    state_d = S_WAIT_CNN;
      S_WAIT_CNN: begin
        if (cnn_done) begin
          tx_d    = {4'h0, cnn_result};
          state_d = S_SEND;
        end
      end
      // tx_done is still high from the previous transfer during SEND
      S_SEND:     state_d = S_WAIT_TX;
      S_WAIT_TX:  if (uart_tx_done) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      tcnt_q  <= '0;
      tx_q    <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      urst_q  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tcnt_q  <= tcnt_d;
      tx_q    <= tx_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      urst_q  <= urst_d;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Every byte is consumed the cycle it is seen, whatever the state.
  assign uart_clr_rx_rdy = uart_rx_rdy;
  assign cnn_start       = (state_q == S_START);
  assign uart_trmt       = (state_q == S_SEND);
  assign busy            = (state_q != S_IDLE);
  assign uart_tx_data    = tx_q;
  assign err             = err_q;
  assign uart_rst        = urst_q;
  assign mem_we          = we_q;
  assign mem_waddr       = waddr_q;
  assign mem_wdata       = wdata_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_frame_ctrl
//   The stimulus tasks know which protocol phase each byte lands in and write
//   the resulting output timeline (write strobes, pulses, level changes) into
//   per-cycle expectation arrays; one negedge process compares every output
//   against that timeline. Literal checks pin the timeline itself.
// -----------------------------------------------------------------------------
module tb_uart_frame_ctrl;

  localparam int AW   = 10;
  localparam int IMG  = 784;
  localparam int TO   = 40;
  localparam int MAXC = 32768;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_rx_rdy = 1'b0;
  logic [7:0]    uart_rx_data = 8'h00;
  logic          uart_clr_rx_rdy;
  logic          uart_trmt;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_done = 1'b1;
  logic          uart_rst;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          cnn_start;
  logic          cnn_done = 1'b0;
  logic [3:0]    cnn_result = 4'h0;
  logic          busy;
  logic          err;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .IMG_BYTES(IMG), .ADDR_W(AW), .SYNC_BYTE(8'hA5), .RX_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .uart_rx_rdy(uart_rx_rdy), .uart_rx_data(uart_rx_data),
    .uart_clr_rx_rdy(uart_clr_rx_rdy),
    .uart_trmt(uart_trmt), .uart_tx_data(uart_tx_data), .uart_tx_done(uart_tx_done),
    .uart_rst(uart_rst),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .cnn_start(cnn_start), .cnn_done(cnn_done), .cnn_result(cnn_result),
    .busy(busy), .err(err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- expected timeline ----------------
  bit            e_we[MAXC];
  logic [AW-1:0] e_addr[MAXC];
  logic [7:0]    e_wdata[MAXC];
  bit            e_start[MAXC];
  bit            e_trmt[MAXC];
  bit            e_urst[MAXC];
  bit            busy_ev[MAXC], busy_v[MAXC];
  bit            err_ev[MAXC],  err_v[MAXC];
  bit            tx_ev[MAXC];
  logic [7:0]    tx_v[MAXC];

  task automatic set_busy(input int k, input bit v); busy_ev[k] = 1'b1; busy_v[k] = v; endtask
  task automatic set_err(input int k, input bit v);  err_ev[k]  = 1'b1; err_v[k]  = v; endtask
  task automatic set_tx(input int k, input logic [7:0] v); tx_ev[k] = 1'b1; tx_v[k] = v; endtask

  task automatic model_reset(input int k);
    for (int i = k; i < MAXC; i++) begin
      e_we[i] = 1'b0; e_start[i] = 1'b0; e_trmt[i] = 1'b0; e_urst[i] = 1'b0;
      busy_ev[i] = 1'b0; err_ev[i] = 1'b0; tx_ev[i] = 1'b0;
    end
    set_busy(k, 1'b0); set_err(k, 1'b0); set_tx(k, 8'h00);
  endtask

  // ---------------- compare process ----------------
  bit            chk_on = 1'b0;
  bit            m_busy, m_err;
  logic [7:0]    m_tx;
  int            n_we = 0, n_start = 0, n_trmt = 0, n_urst = 0;
  logic [AW-1:0] last_addr = '0;
  logic [7:0]    last_wdata = '0;

  always @(negedge clk) begin
    int k;
    if (chk_on && rst_n && cyc < MAXC) begin
      k = cyc;
      if (busy_ev[k]) m_busy = busy_v[k];
      if (err_ev[k])  m_err  = err_v[k];
      if (tx_ev[k])   m_tx   = tx_v[k];
      check("mem_we", mem_we, e_we[k]);
      if (e_we[k]) begin
        check("mem_waddr", mem_waddr, e_addr[k]);
        check("mem_wdata", mem_wdata, e_wdata[k]);
      end
      check("cnn_start", cnn_start, e_start[k]);
      check("uart_trmt", uart_trmt, e_trmt[k]);
      check("uart_rst", uart_rst, e_urst[k]);
      check("busy", busy, m_busy);
      check("err", err, m_err);
      check("uart_tx_data", uart_tx_data, m_tx);
      check("clr_rx_rdy", uart_clr_rx_rdy, uart_rx_rdy);
      if (mem_we) begin n_we++; last_addr = mem_waddr; last_wdata = mem_wdata; end
      if (cnn_start) n_start++;
      if (uart_trmt) n_trmt++;
      if (uart_rst)  n_urst++;
    end
  end

  // ---------------- stimulus ----------------
  function automatic bit coin(input int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction

  function automatic logic [7:0] noise_data();
    return ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom);
  endfunction

  // One clock cycle: inputs change 1 time unit after the rising edge.
  task automatic drive(input bit rdy, input logic [7:0] d);
    @(posedge clk); #1;
    uart_rx_rdy  = rdy;
    uart_rx_data = d;
    cnn_done     = 1'b0;
    cnn_result   = 4'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] b, output int k);
    drive(1'b1, b);
    k = cyc;
  endtask

  // Sync byte then n pixel bytes; pat 0: addr[7:0], 1: all 8'h01, else random.
  task automatic load_frame(input int pat, input int n, output logic [7:0] sum);
    int k;
    logic [7:0] d;
    send(8'hA5, k);
    set_busy(k + 1, 1'b1);
    set_err(k + 1, 1'b0);
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 2));
      d = (pat == 0) ? 8'(i) : (pat == 1) ? 8'h01 : 8'($urandom);
      send(d, k);
      e_we[k + 1] = 1'b1; e_addr[k + 1] = AW'(i); e_wdata[k + 1] = d;
      sum = sum + d;
    end
  endtask

  // Called in the cycle the reply byte was decided; covers SEND and WAIT_TX.
  task automatic reply();
    int n;
    drive(coin(3), noise_data());
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      drive(coin(3), noise_data());
      uart_tx_done = 1'b0;
    end
    drive(coin(3), noise_data());
    uart_tx_done = 1'b1;
    set_busy(cyc + 1, 1'b0);
  endtask

  // Must be called the cycle right after the last accepted frame byte.
  task automatic finish_frame(input logic [3:0] res, input int wait_cyc);
    drive(coin(4), noise_data());
    cnn_done = 1'b1; cnn_result = 4'hF;   // done during START is ignored
    e_start[cyc] = 1'b1;
    for (int i = 0; i < wait_cyc; i++) drive(coin(6), noise_data());
    drive(coin(4), noise_data());
    cnn_done = 1'b1; cnn_result = res;
    set_tx(cyc + 1, {4'h0, res});
    e_trmt[cyc + 1] = 1'b1;
    reply();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_waddr"}, mem_waddr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_cnn_start"}, cnn_start, 0);
    check({tag, "_trmt"}, uart_trmt, 0);
    check({tag, "_tx_data"}, uart_tx_data, 0);
    check({tag, "_uart_rst"}, uart_rst, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_clr"}, uart_clr_rx_rdy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] s;
    logic [3:0] r;
    int k, b_we, b_st, b_tr, b_ur;

    idle(3);
    check_all_zero("reset");
    drive(1'b0, 8'h00);
    rst_n = 1'b1;
    model_reset(cyc);
    chk_on = 1'b1;
    idle(2);

    // Frame 1: pixel = addr[7:0], result 7 after 100 cycles
    b_we = n_we; b_st = n_start; b_tr = n_trmt;
    load_frame(0, IMG, s);
    check("frame1_model_sum", s, 8'hF8);
    finish_frame(4'd7, 100);
    idle(2);
    check("frame1_writes", n_we - b_we, IMG);
    check("frame1_last_addr", last_addr, 783);
    check("frame1_last_data", last_wdata, 8'h0F);
    check("frame1_starts", n_start - b_st, 1);
    check("frame1_trmt", n_trmt - b_tr, 1);
    check("frame1_tx_data", uart_tx_data, 8'h07);
    check("frame1_busy", busy, 0);

    // Junk bytes in IDLE, then a random frame with traffic in WAIT_CNN
    b_we = n_we;
    send(8'h3C, k); send(8'h00, k); idle(2);
    check("junk_writes", n_we - b_we, 0);
    check("junk_busy", busy, 0);
    r = 4'($urandom);
    load_frame(2, IMG, s);
    finish_frame(r, 60);
    idle(2);
    check("frame2_tx_data", uart_tx_data, {4'h0, r});

    // RX timeout: one gap one cycle short of the limit, then silence
    b_we = n_we; b_st = n_start; b_ur = n_urst;
    load_frame(2, 100, s);
    idle(TO - 1);
    send(8'h5A, k);
    e_we[k + 1] = 1'b1; e_addr[k + 1] = AW'(100); e_wdata[k + 1] = 8'h5A;
    idle(TO);
    k = cyc;
    e_urst[k + 1] = 1'b1; set_err(k + 1, 1'b1); set_busy(k + 1, 1'b0);
    idle(3);
    check("timeout_err", err, 1);
    check("timeout_busy", busy, 0);
    check("timeout_urst_pulses", n_urst - b_ur, 1);
    check("timeout_writes", n_we - b_we, 101);
    check("timeout_no_start", n_start - b_st, 0);

    // Next sync clears err
    r = 4'($urandom);
    load_frame(2, IMG, s);
    check("sync_clears_err", err, 0);
    finish_frame(r, 30);
    idle(2);

`ifdef UART_FRAME_CHECKSUM_EN
    // Matching checksum starts the CNN
    load_frame(1, IMG, s);
    check("cks_model_sum", s, 8'h10);
    idle($urandom_range(0, 2));
    send(s, k);
    finish_frame(4'd3, 20);
    idle(2);
    check("cks_good_tx", uart_tx_data, 8'h03);

    // Wrong checksum: err, 8'hEE reply, no CNN start
    b_st = n_start;
    load_frame(1, IMG, s);
    idle(1);
    send(8'h11, k);
    set_err(k + 1, 1'b1); set_tx(k + 1, 8'hEE); e_trmt[k + 1] = 1'b1;
    reply();
    idle(2);
    check("cks_bad_err", err, 1);
    check("cks_bad_tx", uart_tx_data, 8'hEE);
    check("cks_bad_no_start", n_start - b_st, 0);
`endif

    // Reset in the middle of LOAD, then a clean restart at address 0
    load_frame(2, 400, s);
    drive(1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    idle(2);
    rst_n = 1'b1;
    model_reset(cyc);
    idle(2);
    b_we = n_we;
    r = 4'($urandom);
    load_frame(2, IMG, s);
    finish_frame(r, 10);
    idle(3);
    check("restart_writes", n_we - b_we, IMG);
    check("restart_last_addr", last_addr, 783);
    check("restart_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
